// File: rtl/nv_ddr_cmd_sched.sv
// Command front-end for the 16x16x8 NV DDR core: buffers host requests and
// sequences each into the core's START/ACCESS/CLOSE handshake, retrying on power loss.
module nv_ddr_cmd_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [3:0]       req_row,
    input  logic [3:0]       req_col,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic [3:0]       rsp_row,
    output logic [3:0]       rsp_col,
    input  logic             pwr_ok,
    output logic             mem_enable,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic [17:0]      mem_user_data,
    input  logic [7:0]       mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] abort_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 17;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, ACCESS, CLOSE} state_t;

    // Entry layout: [16]=wr, [15:12]=row, [11:8]=col, [7:0]=wdata
    logic [EW-1:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [EW-1:0]    head;
    logic             push, pop, can_issue, abort;

    state_t           state_q;
    logic             mem_enable_q, mem_rd_en_q, mem_wr_en_q;
    logic [17:0]      mem_user_data_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic [3:0]       rsp_row_q, rsp_col_q;
    logic [CNT_W-1:0] abort_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Read commands always present a zero data byte to the core.
    function automatic logic [17:0] pack_cmd(input logic [1:0] flags, input logic [EW-1:0] e);
        return {flags, e[11:8], e[15:12], e[16] ? e[7:0] : 8'h00};
    endfunction

    assign head      = fifo_q[rd_ptr_q];
    assign req_ready = (count_q != DEPTH_C);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == CLOSE) && pwr_ok;
    assign abort     = (state_q != IDLE) && !pwr_ok;
    assign can_issue = (count_q != '0) && pwr_ok && (head[16] || !rsp_valid_q);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_wr, req_row, req_col, req_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sequencer: outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            mem_enable_q    <= 1'b0;
            mem_rd_en_q     <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_user_data_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_row_q       <= '0;
            rsp_col_q       <= '0;
            abort_cnt_q     <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (abort) begin
                state_q         <= IDLE;
                mem_enable_q    <= 1'b0;
                mem_rd_en_q     <= 1'b0;
                mem_wr_en_q     <= 1'b0;
                mem_user_data_q <= '0;
                abort_cnt_q     <= sat_inc(abort_cnt_q);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (can_issue) begin
                            state_q         <= START;
                            mem_enable_q    <= 1'b1;
                            mem_rd_en_q     <= !head[16];
                            mem_wr_en_q     <= head[16];
                            mem_user_data_q <= pack_cmd(2'b00, head);
                        end else begin
                            mem_enable_q    <= 1'b0;
                            mem_rd_en_q     <= 1'b0;
                            mem_wr_en_q     <= 1'b0;
                            mem_user_data_q <= '0;
                        end
                    end
                    START: begin
                        state_q         <= ACCESS;
                        mem_rd_en_q     <= 1'b0;
                        mem_wr_en_q     <= 1'b0;
                        mem_user_data_q <= pack_cmd({!head[16], head[16]}, head);
                    end
                    ACCESS: begin
                        state_q         <= CLOSE;
                        mem_user_data_q <= pack_cmd(2'b00, head);
                    end
                    CLOSE: begin
                        state_q         <= IDLE;
                        mem_enable_q    <= 1'b0;
                        mem_user_data_q <= '0;
                        if (!head[16]) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= mem_rdata;
                            rsp_row_q   <= head[15:12];
                            rsp_col_q   <= head[11:8];
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_enable    = mem_enable_q;
    assign mem_rd_en     = mem_rd_en_q;
    assign mem_wr_en     = mem_wr_en_q;
    assign mem_user_data = mem_user_data_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_row       = rsp_row_q;
    assign rsp_col       = rsp_col_q;
    assign abort_cnt     = abort_cnt_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_nv_ddr_cmd_sched.sv
// Directed bench for nv_ddr_cmd_sched with a byte-array model of the NV DDR core.
module tb_nv_ddr_cmd_sched;
    logic        clk, rst;
    logic        req_valid, req_ready, req_wr;
    logic [3:0]  req_row, req_col;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_row, rsp_col;
    logic        pwr_ok;
    logic        mem_enable, mem_rd_en, mem_wr_en;
    logic [17:0] mem_user_data;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [7:0]  abort_cnt;

    int checks = 0;
    int errors = 0;
    int exp_aborts = 0;
    int waited;

    nv_ddr_cmd_sched #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_row(rsp_row), .rsp_col(rsp_col), .pwr_ok(pwr_ok),
        .mem_enable(mem_enable), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_user_data(mem_user_data), .mem_rdata(mem_rdata),
        .busy(busy), .abort_cnt(abort_cnt)
    );

    // Core model: byte array indexed {row,col}; write lands when the wr flag is presented.
    logic [7:0] core_mem [256];
    always @(posedge clk) begin
        if (mem_enable && mem_user_data[16]) begin
            core_mem[{mem_user_data[11:8], mem_user_data[15:12]}] <= mem_user_data[7:0];
        end
    end
    assign mem_rdata = core_mem[{mem_user_data[11:8], mem_user_data[15:12]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [3:0] row, input logic [3:0] col,
                             input logic [7:0] d);
        req_valid = 1'b1;
        req_wr    = wr;
        req_row   = row;
        req_col   = col;
        req_wdata = d;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        waited = 0;
        while (busy && waited < budget) begin
            tick(1);
            waited++;
        end
        chk(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pwr_ok = 1'b1; rsp_ready = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_row = '0; req_col = '0; req_wdata = '0;
        tick(2);
        chk("rst_hold_enable", 32'(mem_enable), 32'h0);
        rst = 1'b0;
        chk("rst_ready",     32'(req_ready),     32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid),     32'h0);
        chk("rst_rsp_data",  32'(rsp_data),      32'h0);
        chk("rst_user_data", 32'(mem_user_data), 32'h0);
        chk("rst_busy",      32'(busy),          32'h0);
        chk("rst_abort_cnt", 32'(abort_cnt),     32'h0);

        // Write (3,5)=A7 then read it back
        drive_req(1'b1, 4'd3, 4'd5, 8'hA7);
        tick(1);
        drive_req(1'b0, 4'd3, 4'd5, 8'h00);
        chk("t1_busy_queued", 32'(busy), 32'h1);
        tick(1);
        req_valid = 1'b0;
        chk("t1_wr_start_en",  32'(mem_enable),    32'h1);
        chk("t1_wr_start_wr",  32'(mem_wr_en),     32'h1);
        chk("t1_wr_start_rd",  32'(mem_rd_en),     32'h0);
        chk("t1_wr_start_ud",  32'(mem_user_data), 32'h053A7);
        tick(1);
        chk("t1_wr_access_ud", 32'(mem_user_data), 32'h153A7);
        chk("t1_wr_access_wr", 32'(mem_wr_en),     32'h0);
        tick(1);
        chk("t1_wr_close_en",  32'(mem_enable),    32'h1);
        chk("t1_wr_close_ud",  32'(mem_user_data), 32'h053A7);
        tick(1);
        chk("t1_idle_en",      32'(mem_enable),    32'h0);
        chk("t1_idle_ud",      32'(mem_user_data), 32'h0);
        tick(1);
        chk("t1_rd_start_rd",  32'(mem_rd_en),     32'h1);
        chk("t1_rd_start_ud",  32'(mem_user_data), 32'h05300);
        tick(1);
        chk("t1_rd_access_ud", 32'(mem_user_data), 32'h25300);
        tick(1);
        chk("t1_rsp_not_early", 32'(rsp_valid), 32'h0);
        tick(1);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data",  32'(rsp_data),  32'hA7);
        chk("t1_rsp_row",   32'(rsp_row),   32'h3);
        chk("t1_rsp_col",   32'(rsp_col),   32'h5);
        chk("t1_busy_done", 32'(busy),      32'h0);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("t1_rsp_cleared", 32'(rsp_valid), 32'h0);

        // Fill the FIFO while power is down
        pwr_ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, 4'(8 + k), 4'(k), 8'(8'h10 + k));
            tick(1);
        end
        chk("t2_full_ready", 32'(req_ready), 32'h0);
        chk("t2_full_busy",  32'(busy),      32'h1);
        drive_req(1'b1, 4'd12, 4'd4, 8'h14);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t2_held_ready", 32'(req_ready),  32'h0);
            chk("t2_no_enable",  32'(mem_enable), 32'h0);
        end
        pwr_ok = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("t2_free_latency", 32'(waited), 32'd4);
        tick(1);
        req_valid = 1'b0;
        wait_idle("t2_drain", 40);
        chk("t2_core_first", 32'(core_mem[8'h80]), 32'h10);
        chk("t2_core_fifth", 32'(core_mem[8'hC4]), 32'h14);
        chk("t2_no_aborts",  32'(abort_cnt),       32'h0);

        // Power glitch during the ACCESS of a write
        drive_req(1'b1, 4'd1, 4'd2, 8'h3C);
        tick(1);
        req_valid = 1'b0;
        tick(1);
        chk("t3_start_wr", 32'(mem_wr_en), 32'h1);
        tick(1);
        chk("t3_access_ud", 32'(mem_user_data), 32'h1213C);
        pwr_ok = 1'b0;
        tick(1);
        exp_aborts = 1;
        chk("t3_abort_en",   32'(mem_enable),    32'h0);
        chk("t3_abort_ud",   32'(mem_user_data), 32'h0);
        chk("t3_abort_cnt",  32'(abort_cnt),     32'(exp_aborts));
        chk("t3_abort_busy", 32'(busy),          32'h1);
        pwr_ok = 1'b1;
        tick(1);
        chk("t3_retry_wr", 32'(mem_wr_en),     32'h1);
        chk("t3_retry_ud", 32'(mem_user_data), 32'h0213C);
        tick(1);
        chk("t3_retry_access", 32'(mem_user_data), 32'h1213C);
        tick(1);
        chk("t3_retry_close", 32'(mem_enable), 32'h1);
        tick(1);
        chk("t3_popped_once", 32'(busy),      32'h0);
        chk("t3_cnt_kept",    32'(abort_cnt), 32'(exp_aborts));
        tick(1);
        chk("t3_no_reissue", 32'(mem_enable), 32'h0);

        // Read, write, read with the host not accepting responses
        drive_req(1'b0, 4'd3, 4'd5, 8'h00);
        tick(1);
        drive_req(1'b1, 4'd2, 4'd7, 8'h5A);
        tick(1);
        drive_req(1'b0, 4'd1, 4'd2, 8'h00);
        tick(1);
        req_valid = 1'b0;
        tick(2);
        chk("t4_rsp1_valid", 32'(rsp_valid), 32'h1);
        chk("t4_rsp1_data",  32'(rsp_data),  32'hA7);
        tick(1);
        chk("t4_write_not_blocked", 32'(mem_wr_en), 32'h1);
        tick(3);
        chk("t4_read_blocked_a", 32'(mem_enable), 32'h0);
        tick(1);
        chk("t4_read_blocked_b", 32'(mem_enable), 32'h0);
        chk("t4_busy_blocked",   32'(busy),       32'h1);
        chk("t4_core_write",     32'(core_mem[8'h27]), 32'h5A);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("t4_rsp1_cleared", 32'(rsp_valid),  32'h0);
        chk("t4_still_idle",   32'(mem_enable), 32'h0);
        tick(1);
        chk("t4_rd2_start", 32'(mem_rd_en),     32'h1);
        chk("t4_rd2_ud",    32'(mem_user_data), 32'h02100);
        tick(2);
        chk("t4_rsp2_not_early", 32'(rsp_valid), 32'h0);
        tick(1);
        chk("t4_rsp2_valid", 32'(rsp_valid), 32'h1);
        chk("t4_rsp2_data",  32'(rsp_data),  32'h3C);
        chk("t4_rsp2_row",   32'(rsp_row),   32'h1);
        chk("t4_rsp2_col",   32'(rsp_col),   32'h2);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk("t4_rsp2_cleared", 32'(rsp_valid), 32'h0);

        // 300 aborts: each attempt reaches START and loses power there
        pwr_ok = 1'b0;
        drive_req(1'b1, 4'd0, 4'd0, 8'h11);
        tick(1);
        req_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pwr_ok = 1'b1;
            tick(1);
            pwr_ok = 1'b0;
            tick(1);
            if (exp_aborts < 255) exp_aborts++;
            chk("t5_abort_cnt", 32'(abort_cnt), 32'(exp_aborts));
        end
        chk("t5_saturated", 32'(abort_cnt), 32'hFF);
        pwr_ok = 1'b1;
        wait_idle("t5_drain", 20);
        chk("t5_core_write", 32'(core_mem[8'h00]), 32'h11);

        // Reset in the CLOSE of a read with a write still queued
        drive_req(1'b0, 4'd3, 4'd5, 8'h00);
        tick(1);
        drive_req(1'b1, 4'd4, 4'd4, 8'h77);
        tick(1);
        req_valid = 1'b0;
        tick(2);
        chk("t6_in_close", 32'(mem_enable), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_async_en", 32'(mem_enable), 32'h0);
        tick(1);
        rst = 1'b0;
        chk("t6_rsp_valid", 32'(rsp_valid),     32'h0);
        chk("t6_en",        32'(mem_enable),    32'h0);
        chk("t6_rd_wr",     32'({mem_rd_en, mem_wr_en}), 32'h0);
        chk("t6_ud",        32'(mem_user_data), 32'h0);
        chk("t6_busy",      32'(busy),          32'h0);
        chk("t6_ready",     32'(req_ready),     32'h1);
        chk("t6_abort_cnt", 32'(abort_cnt),     32'h0);
        tick(6);
        chk("t6_fifo_dropped", 32'(mem_enable), 32'h0);
        chk("t6_no_response",  32'(rsp_valid),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
